nios_mult_cell_pipelined: RTL and testbench

Parametrised successor to the CPU's fast multiply cell. It produces either the low half or the signed/unsigned high half of a DATA_W x DATA_W product. The result comes out of a valid-tagged pipeline of configurable depth, with stall and flush controls. It sits in the A-stage of the Nios datapath and serves mul, mulxss, mulxsu and mulxuu, so no separate shift/iterate path is needed for the high-half instructions.

---
 rtl/nios_mult_pkg.sv | 38 +++
 rtl/nios_mult_pp_signed.sv | 32 +++
 rtl/nios_mult_cell_pipelined.sv | 169 ++++++++++++++++
 tb/tb_nios_mult_cell_pipelined.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nios_mult_pkg.sv
// Shared definitions for the Nios multiply cell: op encodings and operand
// signedness decode used by the pipelined multiplier.
package nios_mult_pkg;

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULXSS = 2'b01;
  localparam logic [1:0] OP_MULXSU = 2'b10;
  localparam logic [1:0] OP_MULXUU = 2'b11;

  // Signedness of (src1, src2) for one op.
  typedef struct packed {
    logic s1;
    logic s2;
  } op_sign_t;

  // MUL only needs the low half, which is identical for any signedness,
  // so it is treated as unsigned.
  function automatic op_sign_t op_signedness(input logic [1:0] op);
    op_sign_t s;
    s.s1 = 1'b0;
    s.s2 = 1'b0;
    case (op)
      OP_MULXSS: begin
        s.s1 = 1'b1;
        s.s2 = 1'b1;
      end
      OP_MULXSU: s.s1 = 1'b1;
      default: ;
    endcase
    return s;
  endfunction

  // Every MULX* op returns the high half of the product.
  function automatic logic op_is_high(input logic [1:0] op);
    return (op != OP_MUL);
  endfunction

endpackage

// File: rtl/nios_mult_pp_signed.sv
// Registered (W+1)x(W+1) signed partial-product multiplier with enable.
// Kept as a bare multiply-and-register so synthesis can map it onto a DSP.
module nios_mult_pp_signed
  import nios_mult_pkg::*;
#(
  parameter int W = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 i_en,
  input  logic signed [W:0]    i_a,
  input  logic signed [W:0]    i_b,
  output logic signed [2*W+1:0] o_p
);

  logic signed [2*W+1:0] w_a_ext;
  logic signed [2*W+1:0] w_b_ext;
  logic signed [2*W+1:0] w_prod;

  // Extend both operands to full product width; the truncated product is
  // exact because a (W+1)x(W+1) signed product always fits in 2W+2 bits.
  assign w_a_ext = {{(W+1){i_a[W]}}, i_a};
  assign w_b_ext = {{(W+1){i_b[W]}}, i_b};
  assign w_prod  = w_a_ext * w_b_ext;

  // Product register; holds when not enabled so bubbles do not toggle it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  o_p <= '0;
    else if (i_en) o_p <= w_prod;
  end

endmodule

// File: rtl/nios_mult_cell_pipelined.sv
// Pipelined DATA_W x DATA_W multiply cell returning the low half (MUL) or the
// signed/unsigned high half (MULXSS/MULXSU/MULXUU) of the product.
// Handshake: an op is accepted on a clock edge where in_valid=1, stall=0 and
// flush=0; out_valid marks result valid; stall freezes every stage; flush
// clears every valid bit on the next edge and wins over stall.
module nios_mult_cell_pipelined
  import nios_mult_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int PIPE_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  input  logic [1:0]        in_op,
  input  logic [DATA_W-1:0] src1,
  input  logic [DATA_W-1:0] src2,
  input  logic              stall,
  input  logic              flush,
  output logic              out_valid,
  output logic [DATA_W-1:0] result,
  output logic              busy
);

  localparam int HALF_W = DATA_W / 2;
  localparam int PP_W   = DATA_W + 2;
  localparam int PR_W   = 2 * DATA_W;

  // Sign-extend one partial product to the full product width.
  function automatic logic [PR_W-1:0] sext_pp(input logic [PP_W-1:0] x);
    return {{(PR_W-PP_W){x[PP_W-1]}}, x};
  endfunction

  // Pick the requested half of the full product.
  function automatic logic [DATA_W-1:0] sel_half(input logic hi, input logic [PR_W-1:0] p);
    return hi ? p[PR_W-1:DATA_W] : p[DATA_W-1:0];
  endfunction

  op_sign_t w_sign;
  logic     w_accept;
  logic     w_adv1;

  logic signed [HALF_W:0] w_a_lo, w_a_hi, w_b_lo, w_b_hi;
  logic signed [PP_W-1:0] w_pp_ll, w_pp_hl, w_pp_lh, w_pp_hh;
  logic [PR_W-1:0]        w_lo_terms;

  logic r_v1;
  logic r_hi1;

  assign w_sign   = op_signedness(in_op);
  assign w_accept = in_valid & ~stall & ~flush;
  assign w_adv1   = r_v1 & ~stall & ~flush;

  // Low halves are plain magnitudes; only the high halves carry the
  // operand's extension bit.
  assign w_a_lo = {1'b0, src1[HALF_W-1:0]};
  assign w_a_hi = {w_sign.s1 & src1[DATA_W-1], src1[DATA_W-1:HALF_W]};
  assign w_b_lo = {1'b0, src2[HALF_W-1:0]};
  assign w_b_hi = {w_sign.s2 & src2[DATA_W-1], src2[DATA_W-1:HALF_W]};

  nios_mult_pp_signed #(.W(HALF_W)) u_pp_ll (
    .clk(clk), .reset_n(reset_n), .i_en(w_accept), .i_a(w_a_lo), .i_b(w_b_lo), .o_p(w_pp_ll)
  );
  nios_mult_pp_signed #(.W(HALF_W)) u_pp_hl (
    .clk(clk), .reset_n(reset_n), .i_en(w_accept), .i_a(w_a_hi), .i_b(w_b_lo), .o_p(w_pp_hl)
  );
  nios_mult_pp_signed #(.W(HALF_W)) u_pp_lh (
    .clk(clk), .reset_n(reset_n), .i_en(w_accept), .i_a(w_a_lo), .i_b(w_b_hi), .o_p(w_pp_lh)
  );
  nios_mult_pp_signed #(.W(HALF_W)) u_pp_hh (
    .clk(clk), .reset_n(reset_n), .i_en(w_accept), .i_a(w_a_hi), .i_b(w_b_hi), .o_p(w_pp_hh)
  );

  // Stage-1 valid: flush clears, stall holds, otherwise take in_valid.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    r_v1 <= 1'b0;
    else if (flush)  r_v1 <= 1'b0;
    else if (!stall) r_v1 <= in_valid;
  end

  // Stage-1 half select travels with the partial products.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)      r_hi1 <= 1'b0;
    else if (w_accept) r_hi1 <= op_is_high(in_op);
  end

  // Low-order terms: lo*lo plus both cross products at HALF_W.
  assign w_lo_terms = sext_pp(w_pp_ll) + (sext_pp(w_pp_hl) << HALF_W) + (sext_pp(w_pp_lh) << HALF_W);

  if (PIPE_STAGES == 1) begin : g_p1
    logic [PR_W-1:0] w_full;
    assign w_full    = w_lo_terms + (sext_pp(w_pp_hh) << DATA_W);
    assign out_valid = r_v1;
    assign result    = sel_half(r_hi1, w_full);
    assign busy      = r_v1;
  end else if (PIPE_STAGES == 2) begin : g_p2
    logic [PR_W-1:0]   w_full;
    logic              r_v2;
    logic [DATA_W-1:0] r_res2;
    assign w_full = w_lo_terms + (sext_pp(w_pp_hh) << DATA_W);

    // Output valid follows stage 1 unless frozen or flushed.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)    r_v2 <= 1'b0;
      else if (flush)  r_v2 <= 1'b0;
      else if (!stall) r_v2 <= r_v1;
    end

    // Result register only loads real ops, so it holds across bubbles.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)    r_res2 <= '0;
      else if (w_adv1) r_res2 <= sel_half(r_hi1, w_full);
    end

    assign out_valid = r_v2;
    assign result    = r_res2;
    assign busy      = r_v1 | r_v2;
  end else begin : g_p3
    logic              r_v2;
    logic              r_hi2;
    logic [PR_W-1:0]   r_psum2;
    logic [PP_W-1:0]   r_hh2;
    logic              r_v3;
    logic [DATA_W-1:0] r_res3;
    logic              w_adv2;
    logic [PR_W-1:0]   w_full;

    assign w_adv2 = r_v2 & ~stall & ~flush;
    assign w_full = r_psum2 + (sext_pp(r_hh2) << DATA_W);

    // Valid bits for stages 2 and 3.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_v2 <= 1'b0;
        r_v3 <= 1'b0;
      end else if (flush) begin
        r_v2 <= 1'b0;
        r_v3 <= 1'b0;
      end else if (!stall) begin
        r_v2 <= r_v1;
        r_v3 <= r_v2;
      end
    end

    // Stage 2 keeps the low-order partial sum and the pending hi*hi term.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_psum2 <= '0;
        r_hh2   <= '0;
        r_hi2   <= 1'b0;
      end else if (w_adv1) begin
        r_psum2 <= w_lo_terms;
        r_hh2   <= w_pp_hh;
        r_hi2   <= r_hi1;
      end
    end

    // Stage 3 adds hi*hi and selects the half.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)    r_res3 <= '0;
      else if (w_adv2) r_res3 <= sel_half(r_hi2, w_full);
    end

    assign out_valid = r_v3;
    assign result    = r_res3;
    assign busy      = r_v1 | r_v2 | r_v3;
  end

endmodule

// File: tb/tb_nios_mult_cell_pipelined.sv
// Bench for nios_mult_cell_pipelined: directed vector table on the default
// configuration, stall/flush/reset sequences, then a mixed sweep over
// PIPE_STAGES 1..3 and DATA_W=16 checked against a wide reference product.
module tb_nios_mult_cell_pipelined;

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic [1:0]  in_op;
  logic [31:0] src1, src2;
  logic        stall, flush;

  logic        out_valid, busy;
  logic [31:0] result;
  logic        ov_p1, busy_p1, ov_p3, busy_p3, ov_h, busy_h;
  logic [31:0] res_p1, res_p3;
  logic [15:0] res_h;

  int n_tests = 0;
  int n_fail  = 0;
  int n_pop   = 0;
  bit mon_en  = 0;
  bit sw_en   = 0;

  logic [31:0] q_m[$];
  logic [31:0] q_p1[$];
  logic [31:0] q_p3[$];
  logic [31:0] q_h[$];

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[12];

  nios_mult_cell_pipelined #(.DATA_W(32), .PIPE_STAGES(2)) u_dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_op(in_op),
    .src1(src1), .src2(src2), .stall(stall), .flush(flush),
    .out_valid(out_valid), .result(result), .busy(busy)
  );
  nios_mult_cell_pipelined #(.DATA_W(32), .PIPE_STAGES(1)) u_p1 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_op(in_op),
    .src1(src1), .src2(src2), .stall(stall), .flush(flush),
    .out_valid(ov_p1), .result(res_p1), .busy(busy_p1)
  );
  nios_mult_cell_pipelined #(.DATA_W(32), .PIPE_STAGES(3)) u_p3 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_op(in_op),
    .src1(src1), .src2(src2), .stall(stall), .flush(flush),
    .out_valid(ov_p3), .result(res_p3), .busy(busy_p3)
  );
  nios_mult_cell_pipelined #(.DATA_W(16), .PIPE_STAGES(2)) u_h16 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_op(in_op),
    .src1(src1[15:0]), .src2(src2[15:0]), .stall(stall), .flush(flush),
    .out_valid(ov_h), .result(res_h), .busy(busy_h)
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, n_tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

  // Reference: exact product of the (dw+1)-bit extended operands.
  function automatic logic [31:0] ref_res(input int dw, input logic [1:0] op,
                                          input logic [31:0] a, input logic [31:0] b);
    logic signed [65:0] ea, eb, p;
    logic [65:0] sh;
    logic [31:0] m;
    logic sa, sb;
    m  = (dw == 32) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
    sa = (op == 2'b01) || (op == 2'b10);
    sb = (op == 2'b01);
    ea = $signed({34'd0, a & m});
    eb = $signed({34'd0, b & m});
    if (sa && a[dw-1]) ea = ea - (66'sd1 <<< dw);
    if (sb && b[dw-1]) eb = eb - (66'sd1 <<< dw);
    p  = ea * eb;
    sh = (op == 2'b00) ? p : (p >> dw);
    return sh[31:0] & m;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic pop_chk(input string name, inout logic [31:0] q[$], input logic [31:0] act);
    logic [31:0] e;
    if (q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: unexpected out_valid, result 0x%08h, nothing expected", name, act);
    end else begin
      e = q.pop_front();
      chk(name, act, e);
    end
  endtask

  // One clock: score the accepted op, advance, then check any emerging result.
  task automatic cycle();
    logic acc, st;
    acc = in_valid && !stall && !flush;
    st  = stall && !flush;
    if (acc) begin
      q_m.push_back(ref_res(32, in_op, src1, src2));
      q_p1.push_back(ref_res(32, in_op, src1, src2));
      q_p3.push_back(ref_res(32, in_op, src1, src2));
      q_h.push_back(ref_res(16, in_op, src1, src2));
    end
    @(posedge clk);
    #1;
    if (!st) begin
      if (mon_en && out_valid) begin
        n_pop++;
        pop_chk("mon_main", q_m, result);
      end
      if (sw_en) begin
        if (ov_p1) pop_chk("sweep_p1", q_p1, res_p1);
        if (ov_p3) pop_chk("sweep_p3", q_p3, res_p3);
        if (ov_h)  pop_chk("sweep_w16", q_h, {16'd0, res_h});
      end
    end
  endtask

  task automatic drive(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    in_valid = 1'b1;
    in_op    = op;
    src1     = a;
    src2     = b;
  endtask

  task automatic clear_queues();
    q_m.delete();
    q_p1.delete();
    q_p3.delete();
    q_h.delete();
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      4: return 32'h0000_8000;
      default: return $urandom();
    endcase
  endfunction

  logic        snap_ov;
  logic [31:0] snap_res;

  initial begin
    vecs[0]  = '{2'b00, 32'h0001_0003, 32'h0002_0005, 32'h000B_000F};
    vecs[1]  = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[2]  = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001};
    vecs[3]  = '{2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
    vecs[4]  = '{2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    vecs[5]  = '{2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    vecs[6]  = '{2'b11, 32'h8000_0000, 32'h0000_0002, 32'h0000_0001};
    vecs[7]  = '{2'b10, 32'h8000_0000, 32'h8000_0000, 32'hC000_0000};
    vecs[8]  = '{2'b01, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF};
    vecs[9]  = '{2'b00, 32'h1234_5678, 32'h0000_0010, 32'h2345_6780};
    vecs[10] = '{2'b01, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF};
    vecs[11] = '{2'b11, 32'hFFFF_FFFE, 32'h0000_0003, 32'h0000_0002};

    reset_n  = 1'b0;
    in_valid = 1'b0;
    in_op    = 2'b00;
    src1     = '0;
    src2     = '0;
    stall    = 1'b0;
    flush    = 1'b0;
    #12;
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_result", result, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_p3_result", res_p3, 32'd0);
    @(posedge clk);
    #2 reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed table: exact two-cycle latency and value per op.
    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].op, vecs[i].a, vecs[i].b);
      cycle();
      in_valid = 1'b0;
      chk($sformatf("vec%0d_early_valid", i), {31'd0, out_valid}, 32'd0);
      cycle();
      chk($sformatf("vec%0d_valid", i), {31'd0, out_valid}, 32'd1);
      chk($sformatf("vec%0d_result", i), result, vecs[i].exp);
    end

    // Back-to-back mixed ops with a 3-cycle stall in the middle.
    cycle();
    clear_queues();
    n_pop  = 0;
    mon_en = 1;
    drive(2'b00, 32'h0000_0003, 32'h0000_0005);
    cycle();
    drive(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    cycle();
    drive(2'b01, 32'h8000_0000, 32'h8000_0000);
    stall    = 1'b1;
    snap_ov  = out_valid;
    snap_res = result;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("stall_frozen_valid", {31'd0, out_valid}, {31'd0, snap_ov});
      chk("stall_frozen_result", result, snap_res);
    end
    stall = 1'b0;
    cycle();
    drive(2'b10, 32'hFFFF_FFFF, 32'h0000_0002);
    cycle();
    in_valid = 1'b0;
    cycle();
    cycle();
    cycle();
    chk("stall_result_count", n_pop, 32'd4);
    chk("stall_queue_empty", q_m.size(), 32'd0);
    mon_en = 0;

    // Flush together with stall while two ops are in flight.
    drive(2'b11, 32'h1234_5678, 32'h9ABC_DEF0);
    cycle();
    drive(2'b01, 32'hDEAD_BEEF, 32'h0BAD_F00D);
    cycle();
    chk("flush_busy_before", {31'd0, busy}, 32'd1);
    drive(2'b00, 32'h0000_0009, 32'h0000_0009);
    stall = 1'b1;
    flush = 1'b1;
    cycle();
    chk("flush_busy", {31'd0, busy}, 32'd0);
    chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
    stall = 1'b0;
    flush = 1'b0;
    in_valid = 1'b0;
    cycle();
    chk("flush_no_revival", {31'd0, out_valid}, 32'd0);
    drive(2'b00, 32'h0000_0007, 32'h0000_0006);
    cycle();
    in_valid = 1'b0;
    cycle();
    chk("post_flush_valid", {31'd0, out_valid}, 32'd1);
    chk("post_flush_result", result, 32'd42);

    // Asynchronous reset between edges with ops in flight.
    drive(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    cycle();
    drive(2'b01, 32'h8000_0000, 32'h8000_0000);
    cycle();
    in_valid = 1'b0;
    chk("pre_reset_valid", {31'd0, out_valid}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("async_reset_valid", {31'd0, out_valid}, 32'd0);
    chk("async_reset_result", result, 32'd0);
    chk("async_reset_busy", {31'd0, busy}, 32'd0);
    chk("async_reset_p3_busy", {31'd0, busy_p3}, 32'd0);
    @(posedge clk);
    #2 reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_reset_busy", {29'd0, busy_p1, busy_h, busy}, 32'd0);

    // Mixed sweep across all configurations with occasional stalls.
    clear_queues();
    mon_en = 1;
    sw_en  = 1;
    for (int i = 0; i < 400; i++) begin
      if (!stall) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_op    = 2'($urandom_range(0, 3));
        src1     = pick_operand();
        src2     = pick_operand();
      end
      stall = ($urandom_range(0, 9) == 0);
      cycle();
    end
    stall    = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < 6; i++) cycle();
    chk("sweep_main_drained", q_m.size(), 32'd0);
    chk("sweep_p1_drained", q_p1.size(), 32'd0);
    chk("sweep_p3_drained", q_p3.size(), 32'd0);
    chk("sweep_w16_drained", q_h.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
